wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Shares one Wishbone B4 classic slave port (32-bit data, 30-bit word address,
//  4-bit byte select) between N_MASTERS masters (CPU fetch, CPU memory unit, DMA).
//  Round-robin grant, held for the owner's whole cyc cycle.
//  Bus timeout watchdog answers a stalled transfer with err.
//  Sits between the CPU's memory request units and the system interconnect.
// PARAMETERS
//  N_MASTERS       2    number of requesting masters (1..8)
//  TIMEOUT_CYCLES  255  stb-without-ack cycles before err; 0 disables watchdog
// PORTS
//  clk_i     in   1        bus clock
//  rst_ni    in   1        asynchronous reset, active low
//  m_cyc_i   in   N        per-master cyc
//  m_stb_i   in   N        per-master stb
//  m_we_i    in   N        per-master we
//  m_sel_i   in   4*N      per-master sel, master k at [4k+3:4k]
//  m_adr_i   in   30*N     per-master word address, master k at [30k+29:30k]
//  m_dat_i   in   32*N     per-master write data, master k at [32k+31:32k]
//  m_dat_o   out  32       read data, broadcast to all masters (= s_dat_i)
//  m_ack_o   out  N        per-master ack
//  m_err_o   out  N        per-master err (timeout)
//  s_cyc_o   out  1        slave-side cyc
//  s_stb_o   out  1        slave-side stb
//  s_we_o    out  1        slave-side we
//  s_sel_o   out  4        slave-side sel
//  s_adr_o   out  30       slave-side address
//  s_dat_o   out  32       slave-side write data
//  s_dat_i   in   32       slave read data
//  s_ack_i   in   1        slave ack
//  grant_o   out  N        one-hot current owner, 0 when idle
//  busy_o    out  1        1 in any state other than IDLE
// BEHAVIOUR
//  States: IDLE, OWNED, ERRWAIT; registers: owner, last_owner, tmo_cnt.
//  Reset (async, rst_ni=0): state=IDLE, grant_o=0, last_owner=N_MASTERS-1,
//   tmo_cnt=0. All outputs 0 while idle, so master 0 has first priority.
//  IDLE: if any m_cyc_i set, pick first set bit scanning last_owner+1, +2, ...
//   mod N_MASTERS. Register owner, go to OWNED. Grant latency: 1 clk from cyc
//   to s_cyc_o.
//  OWNED:
//   - s_cyc_o/stb/we/sel/adr/dat_o combinationally = owner's inputs.
//   - m_ack_o[owner] = s_ack_i & m_stb_i[owner]; other acks/errs are 0.
//   - Grant is locked while m_cyc_i[owner]=1, across any number of stb/ack
//     beats; other requests wait.
//   - m_cyc_i[owner]=0 -> IDLE next clk, last_owner=owner.
//   - Always one idle clk between owners (s_cyc_o=0 that cycle).
//  Watchdog (TIMEOUT_CYCLES>0):
//   - tmo_cnt clears on IDLE, on s_ack_i, or when m_stb_i[owner]=0.
//   - Otherwise tmo_cnt increments each clk in OWNED.
//   - When tmo_cnt reaches TIMEOUT_CYCLES-1 with no ack: m_err_o[owner]=1
//     for exactly that clk, then ERRWAIT.
//   - Ack arriving on the final count wins; no err is raised.
//  ERRWAIT: s_cyc_o=s_stb_o=0, no ack/err.
//   - Stay until m_cyc_i[owner]=0, then IDLE, last_owner=owner.
//  tmo_cnt width: clog2(TIMEOUT_CYCLES+1); it never wraps, saturating at the
//   terminal count.
//  Simultaneous new requests and an owner release in the same clk: release
//   first, arbitration happens in the following IDLE clk.
//  Reset mid-transaction: outputs drop immediately (async), with no ack or err
//   to the interrupted master.
//  Masters that raise stb without cyc are ignored (never granted).
// TESTING
//  1 single: m0 write adr=0x3FC0, dat=0xDEDEDEDE, sel=0x1; slave acks after
//    2 clk -> s_cyc_o 1 clk after m_cyc_i, m_ack_o=01 for 1 clk, grant_o=01.
//  2 contention: m0,m1 raise cyc same clk after reset -> m0 granted first.
//    m0 drops cyc -> 1 idle clk, then grant_o=10.
//  3 round robin: m0,m1 both re-request continuously for 6 transfers ->
//    grants strictly alternate 0,1,0,1,0,1.
//  4 lock: m1 owns and issues 3 stb/ack beats with cyc held while m0 requests
//    -> no grant change until m1 drops cyc.
//  5 timeout: TIMEOUT_CYCLES=4, slave never acks -> m_err_o[owner] pulses on
//    4th stb clk, s_cyc_o=0 next clk, IDLE after master drops cyc.
//    Ack on 4th clk -> ack only, no err.
//  6 reset: assert rst_ni=0 mid-beat -> s_cyc_o, s_stb_o, grant_o=0 without
//    clock edge. After release, m0 regains priority.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one Wishbone B4 classic slave port between N_MASTERS
// masters. Grants rotate round-robin. A grant stays locked for the owner's whole
// cyc cycle. A watchdog answers a stalled strobe with err after TIMEOUT_CYCLES
// clocks and parks the owner in ERRWAIT until it drops cyc.
module wb_bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [4*N_MASTERS-1:0]  m_sel_i,
  input  logic [30*N_MASTERS-1:0] m_adr_i,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [29:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    grant_o,
  output logic                    busy_o
);

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_ERRWAIT = 2'd2
  } state_t;

  state_t               r_state;
  logic [OW-1:0]        r_owner;
  logic [OW-1:0]        r_last_owner;
  logic [TW-1:0]        r_tmo_cnt;
  logic [N_MASTERS-1:0] r_grant;

  logic                 w_found;
  logic [OW-1:0]        w_pick;
  logic [OW-1:0]        w_cand;
  logic                 w_o_cyc;
  logic                 w_o_stb;
  logic                 w_o_we;
  logic [3:0]           w_o_sel;
  logic [29:0]          w_o_adr;
  logic [31:0]          w_o_dat;
  logic [N_MASTERS-1:0] w_owner_oh;
  logic                 w_owned;
  logic                 w_tmo_hit;

  function automatic logic [N_MASTERS-1:0] f_onehot(input logic [OW-1:0] idx);
    logic [N_MASTERS-1:0] v;
    v = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      v[k] = (idx == OW'(k));
    end
    return v;
  endfunction

  // Round-robin pick: first requesting master after last_owner, wrapping.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_owner;
    w_cand  = r_last_owner;
    for (int k = 0; k < N_MASTERS; k++) begin
      w_cand = (w_cand == OW'(N_MASTERS - 1)) ? '0 : w_cand + OW'(1);
      if (!w_found && m_cyc_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Select the current owner's request fields.
  always_comb begin
    w_o_cyc    = 1'b0;
    w_o_stb    = 1'b0;
    w_o_we     = 1'b0;
    w_o_sel    = '0;
    w_o_adr    = '0;
    w_o_dat    = '0;
    w_owner_oh = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (r_owner == OW'(k)) begin
        w_o_cyc       = m_cyc_i[k];
        w_o_stb       = m_stb_i[k];
        w_o_we        = m_we_i[k];
        w_o_sel       = m_sel_i[4*k +: 4];
        w_o_adr       = m_adr_i[30*k +: 30];
        w_o_dat       = m_dat_i[32*k +: 32];
        w_owner_oh[k] = 1'b1;
      end
    end
  end

  assign w_owned   = (r_state == ST_OWNED);
  // An ack on the terminal count wins over the timeout.
  assign w_tmo_hit = (TIMEOUT_CYCLES > 0) && w_owned && w_o_cyc && w_o_stb &&
                     !s_ack_i && (r_tmo_cnt == TMO_LAST);

  assign s_cyc_o = w_owned & w_o_cyc;
  assign s_stb_o = w_owned & w_o_stb;
  assign s_we_o  = w_owned & w_o_we;
  assign s_sel_o = w_owned ? w_o_sel : 4'h0;
  assign s_adr_o = w_owned ? w_o_adr : 30'h0;
  assign s_dat_o = w_owned ? w_o_dat : 32'h0;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = (w_owned && w_o_stb && s_ack_i) ? w_owner_oh : '0;
  assign m_err_o = w_tmo_hit ? w_owner_oh : '0;
  assign grant_o = r_grant;
  assign busy_o  = (r_state != ST_IDLE);

  // Ownership FSM with the watchdog counter and the registered grant vector.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(N_MASTERS - 1);
      r_tmo_cnt    <= '0;
      r_grant      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_found) begin
            r_owner <= w_pick;
            r_grant <= f_onehot(w_pick);
            r_state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!w_o_cyc) begin
            r_last_owner <= r_owner;
            r_grant      <= '0;
            r_tmo_cnt    <= '0;
            r_state      <= ST_IDLE;
          end else if (w_tmo_hit) begin
            r_tmo_cnt <= '0;
            r_state   <= ST_ERRWAIT;
          end else if (s_ack_i || !w_o_stb) begin
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt != TMO_LAST) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_ERRWAIT: begin
          if (!w_o_cyc) begin
            r_last_owner <= r_owner;
            r_grant      <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Testbench for wb_bus_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_wb_bus_arbiter;

  localparam int N = 2;
  localparam int T = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [4*N-1:0]    m_sel_i;
  logic [30*N-1:0]   m_adr_i;
  logic [32*N-1:0]   m_dat_i;
  logic [31:0]       m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [29:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i;
  logic [N-1:0]      grant_o;
  logic              busy_o;

  wb_bus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the bus (-1 = nobody), who held it last,
  // whether the holder timed out, and how many consecutive stalled strobes so far.
  int mdl_owner, mdl_last, mdl_stall;
  bit mdl_errd;

  // Observation log used by the directed scenarios.
  int           ack_cnt[N];
  int           err_cnt[N];
  logic [N-1:0] last_ack;
  logic [N-1:0] prev_grant;
  int           grant_log[$];

  function automatic int mdl_pick();
    for (int d = 1; d <= N; d++) begin
      int c;
      c = (mdl_last + d) % N;
      if (m_cyc_i[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit mdl_timeout_now();
    if (mdl_owner < 0 || mdl_errd) return 1'b0;
    return m_cyc_i[mdl_owner] && m_stb_i[mdl_owner] && !s_ack_i && (mdl_stall == T - 1);
  endfunction

  task automatic clear_stats();
    for (int k = 0; k < N; k++) begin
      ack_cnt[k] = 0;
      err_cnt[k] = 0;
    end
    last_ack   = '0;
    prev_grant = '0;
    grant_log.delete();
  endtask

  task automatic compare_outputs();
    bit           active;
    logic [N-1:0] e_ack, e_err, e_grant;
    logic         e_cyc, e_stb, e_we;
    logic [3:0]   e_sel;
    logic [29:0]  e_adr;
    logic [31:0]  e_dat;
    active  = (mdl_owner >= 0) && !mdl_errd;
    e_ack = '0; e_err = '0; e_grant = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_sel = '0; e_adr = '0; e_dat = '0;
    if (mdl_owner >= 0) e_grant[mdl_owner] = 1'b1;
    if (active) begin
      e_cyc = m_cyc_i[mdl_owner];
      e_stb = m_stb_i[mdl_owner];
      e_we  = m_we_i[mdl_owner];
      e_sel = m_sel_i[4*mdl_owner +: 4];
      e_adr = m_adr_i[30*mdl_owner +: 30];
      e_dat = m_dat_i[32*mdl_owner +: 32];
      if (m_stb_i[mdl_owner] && s_ack_i) e_ack[mdl_owner] = 1'b1;
      if (mdl_timeout_now()) e_err[mdl_owner] = 1'b1;
    end
    check("s_cyc", s_cyc_o, e_cyc);
    check("s_stb", s_stb_o, e_stb);
    check("s_we", s_we_o, e_we);
    check("s_sel", s_sel_o, e_sel);
    check("s_adr", s_adr_o, e_adr);
    check("s_dat", s_dat_o, e_dat);
    check("m_dat", m_dat_o, s_dat_i);
    check("m_ack", m_ack_o, e_ack);
    check("m_err", m_err_o, e_err);
    check("grant", grant_o, e_grant);
    check("busy", busy_o, mdl_owner >= 0);
    for (int k = 0; k < N; k++) begin
      ack_cnt[k] += int'(m_ack_o[k]);
      err_cnt[k] += int'(m_err_o[k]);
    end
    last_ack = m_ack_o;
    if (grant_o != '0 && grant_o != prev_grant) begin
      for (int k = 0; k < N; k++) if (grant_o[k]) grant_log.push_back(k);
    end
    prev_grant = grant_o;
  endtask

  task automatic mdl_update();
    if (mdl_owner < 0) begin
      mdl_owner = mdl_pick();
      mdl_stall = 0;
      mdl_errd  = 1'b0;
    end else if (!m_cyc_i[mdl_owner]) begin
      mdl_last  = mdl_owner;
      mdl_owner = -1;
      mdl_stall = 0;
      mdl_errd  = 1'b0;
    end else if (mdl_errd) begin
      mdl_stall = 0;
    end else if (mdl_timeout_now()) begin
      mdl_errd  = 1'b1;
      mdl_stall = 0;
    end else if (s_ack_i || !m_stb_i[mdl_owner]) begin
      mdl_stall = 0;
    end else begin
      mdl_stall++;
    end
  endtask

  // One bus clock: compare mid-cycle, then advance the model with the same inputs.
  task automatic step();
    @(negedge clk_i);
    compare_outputs();
    @(posedge clk_i);
    mdl_update();
    #1;
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [3:0] sel, input logic [29:0] adr, input logic [31:0] dat);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_sel_i[4*k +: 4]   = sel;
    m_adr_i[30*k +: 30] = adr;
    m_dat_i[32*k +: 32] = dat;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni    = 1'b1;
    mdl_owner = -1;
    mdl_last  = N - 1;
    mdl_stall = 0;
    mdl_errd  = 1'b0;
    clear_stats();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int budget;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    @(posedge clk_i);
    #1;

    // Single write from master 0, slave acks on the second owned clock.
    do_reset();
    set_m(0, 1, 1, 1, 4'h1, 30'h3FC0, 32'hDEDEDEDE);
    s_dat_i = 32'h1234_5678;
    step();
    step();
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step();
    step();
    check("t1_ack_count", ack_cnt[0], 1);
    check("t1_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t1_grant_first", grant_log[0], 0);

    // Simultaneous requests right after reset: master 0 first, then master 1.
    do_reset();
    set_m(0, 1, 1, 0, 4'hF, 30'h100, 32'hA);
    set_m(1, 1, 1, 0, 4'hF, 30'h200, 32'hB);
    s_ack_i = 1'b1;
    step();
    step();
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step();
    step();
    step();
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    s_ack_i = 1'b0;
    step();
    step();
    check("t2_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t2_first", grant_log[0], 0);
      check("t2_second", grant_log[1], 1);
    end

    // Both masters re-request continuously: grants must alternate.
    do_reset();
    s_ack_i = 1'b1;
    budget  = 0;
    while (grant_log.size() < 6 && budget < 100) begin
      for (int k = 0; k < N; k++)
        set_m(k, !last_ack[k], 1, 1, 4'hF, 30'(k + 1), $urandom);
      step();
      budget++;
    end
    check("t3_budget", budget < 100, 1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("t3_order_%0d", i), grant_log[i], i % 2);
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
    step();
    step();

    // Lock: master 1 holds cyc across three beats while master 0 waits.
    do_reset();
    set_m(1, 1, 1, 0, 4'h3, 30'h55, 32'h0);
    step();
    set_m(0, 1, 1, 1, 4'hC, 30'hAA, 32'hCAFE);
    for (int b = 0; b < 5; b++) begin
      s_ack_i = (b % 2 == 0);
      step();
    end
    s_ack_i = 1'b0;
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step();
    check("t4_lock_grants", grant_log.size(), 1);
    check("t4_m1_beats", ack_cnt[1], 3);
    check("t4_m0_acks", ack_cnt[0], 0);
    step();
    step();
    check("t4_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) check("t4_next_owner", grant_log[1], 0);
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step();
    step();

    // Watchdog: slave never acks, err on the fourth stalled strobe.
    do_reset();
    set_m(0, 1, 1, 0, 4'hF, 30'h77, 32'h0);
    step();
    step(); step(); step();
    check("t5_no_err_early", err_cnt[0], 0);
    step();
    check("t5_err_pulse", err_cnt[0], 1);
    step();
    step();
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step();
    step();
    check("t5_err_total", err_cnt[0], 1);
    check("t5_no_ack", ack_cnt[0], 0);
    // Ack on the terminal count beats the timeout.
    clear_stats();
    set_m(0, 1, 1, 0, 4'hF, 30'h78, 32'h0);
    step();
    step(); step(); step();
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step();
    step();
    check("t5_late_ack", ack_cnt[0], 1);
    check("t5_late_no_err", err_cnt[0], 0);

    // Asynchronous reset in the middle of a beat.
    do_reset();
    set_m(1, 1, 1, 1, 4'hF, 30'h99, 32'h1);
    step();
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_s_cyc", s_cyc_o, 0);
    check("t6_s_stb", s_stb_o, 0);
    check("t6_grant", grant_o, 0);
    check("t6_ack", m_ack_o, 0);
    check("t6_err", m_err_o, 0);
    mdl_owner = -1; mdl_last = N - 1; mdl_stall = 0; mdl_errd = 1'b0;
    clear_stats();
    set_m(0, 1, 1, 0, 4'h1, 30'h11, 32'h2);
    rst_ni = 1'b1;
    step();
    step();
    check("t6_m0_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    m_cyc_i = '0; m_stb_i = '0;
    step();
    step();

    // Random traffic, including strobes without cyc.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        bit cyc;
        cyc = m_cyc_i[k];
        if ($urandom_range(5) == 0) cyc = !cyc;
        set_m(k, cyc, cyc ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0),
              $urandom_range(1), 4'($urandom), 30'($urandom), $urandom);
      end
      s_ack_i = ($urandom_range(2) == 0);
      s_dat_i = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
